regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port GPR file for the pipelined core, successor to the 2R/1W file.
//  NUM_RD read ports and two write ports: W0 carries the WB result, W1 carries the second
//  (load/HI-LO) writeback. Adds a per-register pending scoreboard for hazard stalls.
//  Adds a post-reset clear sequencer that zeroes the array before the pipeline issues.
// PARAMETERS
//  DW       32  data width per register
//  AW        5  address width; DEPTH = 2**AW registers
//  NUM_RD    2  number of read ports (1..4)
//  ZERO_REG  1  1: register 0 reads 0, ignores writes, is never pending
// PORTS
//  clk         in   1          core clock, rising edge
//  rst         in   1          synchronous reset, active high
//  raddr       in   NUM_RD*AW  read addresses; port i = raddr[i*AW +: AW]
//  rdata       out  NUM_RD*DW  read data; port i = rdata[i*DW +: DW]
//  rd_pending  out  NUM_RD     port i's register has an outstanding producer
//  we0/we1     in   1          write enables
//  waddr0/1    in   AW         write addresses
//  wdata0/1    in   DW         write data
//  sb_set      in   1          issue stage claims destination sb_addr (marks it pending)
//  sb_addr     in   AW         destination being claimed
//  init_busy   out  1          clear sequencer active; issue must stall
// BEHAVIOUR
//  Reset: state <= CLEAR, counter <= 0, pending <= 0.
//  Reset values: init_busy = 1, rd_pending = 0, rdata = 0.
//  FSM CLEAR: writes 0 to array[counter] each cycle; counter increments by 1.
//   After counter = DEPTH-1 is written, go to READY.
//   init_busy = 1 for exactly DEPTH cycles after rst deasserts.
//  FSM READY: terminal state; only rst leaves it.
//  During CLEAR: we0/we1/sb_set are ignored; rdata = 0 and rd_pending = 0 on all ports.
//  Reset mid-CLEAR or mid-READY restarts CLEAR from counter 0 and drops all pending bits.
//  Write: on posedge, if weN, array[waddrN] <= wdataN.
//   If we0 and we1 target the same address, W1 wins.
//   A write to reg 0 is dropped when ZERO_REG = 1.
//  Read: combinational, zero latency. Reg 0 reads 0 when ZERO_REG = 1.
//  Scoreboard: pending[sb_addr] <= 1 on sb_set.
//   pending[waddrN] <= 0 on any accepted write.
//   If sb_set and a write hit the same address in one cycle, set wins (new producer).
//   Re-setting a bit that is already pending is a no-op.
//  rd_pending[i] = pending[raddr_i]. With bypass enabled, this is masked when a same-cycle
//   write hits raddr_i.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN.
//  Defined: write-to-read forwarding. rdata_i = wdata1 if (we1 && waddr1 == raddr_i).
//   Otherwise wdata0 if (we0 && waddr0 == raddr_i). Otherwise array[raddr_i].
//   Reg 0 and CLEAR rules take precedence over forwarding.
//  Undefined: rdata is array only; a value written at edge N is readable after edge N.
//   rd_pending is unmasked.
// STRUCTURE
//  Header regfile_defs.vh (included alongside defines.vh):
//   RF_ST_CLEAR / RF_ST_READY state encodings.
//   Default DW/AW/NUM_RD constants.
//  Sub-module regfile_scoreboard holds the pending bit vector plus its set/clear and
//   priority logic; it takes the write enables/addresses and sb_set/sb_addr as inputs.
//  regfile_mp holds the array, CLEAR FSM and counter, the read muxes and the bypass muxes.
// TESTING
//  1. rst for 1 cycle, then release: init_busy = 1 for 32 cycles, then 0.
//     Every register then reads 32'h0.
//  2. READY, we0 = 1, waddr0 = 3, wdata0 = 32'hDEAD_BEEF; raddr port0 = 3.
//     Bypass: rdata0 = DEADBEEF in the same cycle. No bypass: DEADBEEF on the next cycle.
//  3. Same cycle: we0 (addr 7, 32'h1) and we1 (addr 7, 32'h2). Next cycle reg 7 reads 32'h2.
//  4. sb_set addr 9, then read 9: rd_pending = 1 until a write to 9 lands.
//     Then sb_set 9 together with we0 to 9: pending stays 1.
//  5. we1 to addr 0 with 32'hFFFF_FFFF and sb_set addr 0: reg 0 reads 0, rd_pending = 0.
//  6. rst asserted at cycle 10 of CLEAR: init_busy held; a full 32-cycle clear reruns.
//     A write attempted during CLEAR has no effect.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional feature: define REGFILE_BYPASS_EN for write-to-read forwarding.
package regfile_mp_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_AW     = 5;
  localparam int DEF_NUM_RD = 2;

  // Clear sequencer states: CLEAR zeroes the array after reset, READY is terminal.
  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, two write ports, scoreboard claim and init status.
// master = pipeline side, slave = register file side.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*AW-1:0] raddr;
  logic [NUM_RD*DW-1:0] rdata;
  logic [NUM_RD-1:0]    rd_pending;
  logic                 we0;
  logic [AW-1:0]        waddr0;
  logic [DW-1:0]        wdata0;
  logic                 we1;
  logic [AW-1:0]        waddr1;
  logic [DW-1:0]        wdata1;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;
  logic                 init_busy;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, sb_set, sb_addr,
    input  rdata, rd_pending, init_busy
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, sb_set, sb_addr,
    output rdata, rd_pending, init_busy
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: set when issue claims a destination, cleared when a
// write to that register lands. A same-cycle claim beats the clear (new producer).
module regfile_mp_scoreboard #(
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  output logic [2**AW-1:0] pending
);

  logic [2**AW-1:0] pending_nx;
  logic             zero_en;

  assign zero_en = (ZERO_REG != 0);

  // Next pending vector: clears first, then the claim so it overrides a same-cycle write.
  always_comb begin
    pending_nx = pending;
    if (en) begin
      if (we0 && !(zero_en && waddr0 == '0)) pending_nx[waddr0] = 1'b0;
      if (we1 && !(zero_en && waddr1 == '0)) pending_nx[waddr1] = 1'b0;
      if (sb_set && !(zero_en && sb_addr == '0)) pending_nx[sb_addr] = 1'b1;
    end
  end

  // Pending register; reset drops every outstanding producer.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nx;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports, two write ports (W1 has
// priority), pending scoreboard and a post-reset clear sequencer.
// Optional REGFILE_BYPASS_EN: forward same-cycle write data to matching read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**AW;

  rf_state_e        state;
  rf_state_e        state_nx;
  logic [AW-1:0]    counter;
  logic             clearing;
  logic             ready;
  logic             zero_en;
  logic             wr0;
  logic             wr1;
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pending;

  assign zero_en = (ZERO_REG != 0);

  // Writes are accepted only in READY, outside reset, and never to a hardwired reg 0.
  assign wr0 = bus.we0 && ready && !rst && !(zero_en && bus.waddr0 == '0);
  assign wr1 = bus.we1 && ready && !rst && !(zero_en && bus.waddr1 == '0);

  // State register and clear counter; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_ST_CLEAR;
      counter <= '0;
    end else begin
      state <= state_nx;
      if (clearing) counter <= counter + 1'b1;
    end
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    state_nx = state;
    case (state)
      RF_ST_CLEAR: if (counter == AW'(DEPTH - 1)) state_nx = RF_ST_READY;
      RF_ST_READY: state_nx = RF_ST_READY;
      default:     state_nx = RF_ST_CLEAR;
    endcase
  end

  // State decode driving the array, scoreboard enable and issue stall.
  always_comb begin
    clearing = (state == RF_ST_CLEAR);
    ready    = (state == RF_ST_READY);
  end

  assign bus.init_busy = clearing;

  // Array update: sequencer zeroes one entry per cycle, otherwise the two write ports.
  // NOTE: the array has no reset term; the clear sequencer zeroes it after reset, so
  // the storage stays mappable to RAM-style cells. The later non-blocking assignment
  // wins when both ports hit the same address, which gives W1 priority.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[counter] <= '0;
    end else begin
      if (wr0) mem[bus.waddr0] <= bus.wdata0;
      if (wr1) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  regfile_mp_scoreboard #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .en      (ready),
    .we0     (bus.we0),
    .waddr0  (bus.waddr0),
    .we1     (bus.we1),
    .waddr1  (bus.waddr1),
    .sb_set  (bus.sb_set),
    .sb_addr (bus.sb_addr),
    .pending (pending)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          pend;

    // Read mux: array (or forwarded write data), forced to 0 for reg 0 and during CLEAR.
    always_comb begin
      ra   = bus.raddr[i*AW +: AW];
      rd   = mem[ra];
      pend = pending[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr1 && bus.waddr1 == ra) begin
        rd   = bus.wdata1;
        pend = 1'b0;
      end else if (wr0 && bus.waddr0 == ra) begin
        rd   = bus.wdata0;
        pend = 1'b0;
      end
`endif
      if (!ready || (zero_en && ra == '0)) begin
        rd   = '0;
        pend = 1'b0;
      end
    end

    assign bus.rdata[i*DW +: DW] = rd;
    assign bus.rd_pending[i]     = pend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DW=32, AW=5, NUM_RD=2, ZERO_REG=1).
// Expected same-cycle values follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) bus ();

  regfile_mp #(.DW(32), .AW(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0     = 1'b0;
    bus.we1     = 1'b0;
    bus.sb_set  = 1'b0;
    bus.waddr0  = '0;
    bus.waddr1  = '0;
    bus.wdata0  = '0;
    bus.wdata1  = '0;
    bus.sb_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int n;
    idle();
    bus.raddr = '0;

    // 1. Reset, then exactly 32 busy cycles, then every register reads zero.
    tick();
    tick();
    bus.raddr = {5'd9, 5'd3};
    #1;
    check("rst_init_busy", 32'(bus.init_busy), 32'd1);
    check("rst_rdata0", bus.rdata[31:0], 32'h0);
    check("rst_rd_pending", 32'(bus.rd_pending), 32'h0);
    rst = 1'b0;
    n = 0;
    while (bus.init_busy && n < 100) begin
      tick();
      n++;
    end
    check("clear_cycles", 32'(n), 32'd32);
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(31 - a), 5'(a)};
      #1;
      check("cleared_p0", bus.rdata[31:0], 32'h0);
      check("cleared_p1", bus.rdata[63:32], 32'h0);
    end

    // 2. Write DEADBEEF to reg 3 on W0.
    bus.raddr  = {5'd0, 5'd3};
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd3;
    bus.wdata0 = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("w0_same_cycle", bus.rdata[31:0], 32'hDEAD_BEEF);
`else
    check("w0_same_cycle", bus.rdata[31:0], 32'h0);
`endif
    tick();
    idle();
    #1;
    check("w0_next_cycle", bus.rdata[31:0], 32'hDEAD_BEEF);

    // 3. Both ports write reg 7: W1 wins.
    bus.raddr  = {5'd3, 5'd7};
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd7;
    bus.wdata0 = 32'h1;
    bus.we1    = 1'b1;
    bus.waddr1 = 5'd7;
    bus.wdata1 = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("w1_wins_same", bus.rdata[31:0], 32'h2);
`else
    check("w1_wins_same", bus.rdata[31:0], 32'h0);
`endif
    tick();
    idle();
    #1;
    check("w1_wins_next", bus.rdata[31:0], 32'h2);
    check("reg3_kept", bus.rdata[63:32], 32'hDEAD_BEEF);

    // 4. Scoreboard on reg 9 (read through port 1).
    bus.raddr = {5'd9, 5'd0};
    #1;
    check("sb9_idle", 32'(bus.rd_pending[1]), 32'd0);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd9;
    tick();
    idle();
    #1;
    check("sb9_set", 32'(bus.rd_pending[1]), 32'd1);
    tick();
    check("sb9_held", 32'(bus.rd_pending[1]), 32'd1);
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd9;
    bus.wdata0 = 32'h99;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("sb9_write_mask", 32'(bus.rd_pending[1]), 32'd0);
`else
    check("sb9_write_mask", 32'(bus.rd_pending[1]), 32'd1);
`endif
    tick();
    idle();
    #1;
    check("sb9_cleared", 32'(bus.rd_pending[1]), 32'd0);
    check("reg9_data", bus.rdata[63:32], 32'h99);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd9;
    bus.we0     = 1'b1;
    bus.waddr0  = 5'd9;
    bus.wdata0  = 32'hAA;
    tick();
    idle();
    #1;
    check("sb9_set_wins", 32'(bus.rd_pending[1]), 32'd1);
    check("reg9_data_aa", bus.rdata[63:32], 32'hAA);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd9;
    tick();
    idle();
    #1;
    check("sb9_reset_noop", 32'(bus.rd_pending[1]), 32'd1);
    bus.we1    = 1'b1;
    bus.waddr1 = 5'd9;
    bus.wdata1 = 32'hBB;
    tick();
    idle();
    #1;
    check("sb9_w1_clear", 32'(bus.rd_pending[1]), 32'd0);
    check("reg9_data_bb", bus.rdata[63:32], 32'hBB);

    // 5. Reg 0 ignores writes and claims.
    bus.raddr   = {5'd9, 5'd0};
    bus.we1     = 1'b1;
    bus.waddr1  = 5'd0;
    bus.wdata1  = 32'hFFFF_FFFF;
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd0;
    #1;
    check("r0_same_cycle", bus.rdata[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("r0_data", bus.rdata[31:0], 32'h0);
    check("r0_pending", 32'(bus.rd_pending[0]), 32'd0);

    // 6. Seed state, reset mid-CLEAR, then a full clear with a write attempt inside it.
    bus.we0     = 1'b1;
    bus.waddr0  = 5'd20;
    bus.wdata0  = 32'h2020;
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd12;
    tick();
    idle();
    bus.raddr = {5'd12, 5'd20};
    #1;
    check("reg20_seed", bus.rdata[31:0], 32'h2020);
    check("sb12_seed", 32'(bus.rd_pending[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (n < 10) begin
      tick();
      n++;
    end
    check("midclear_busy", 32'(bus.init_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rerst_busy", 32'(bus.init_busy), 32'd1);
    rst = 1'b0;
    n = 0;
    while (bus.init_busy && n < 100) begin
      if (n == 10) begin
        bus.raddr   = {5'd12, 5'd5};
        bus.we0     = 1'b1;
        bus.waddr0  = 5'd5;
        bus.wdata0  = 32'h55;
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd5;
        #1;
        check("clear_rdata", bus.rdata[31:0], 32'h0);
        check("clear_pending", 32'(bus.rd_pending[0]), 32'd0);
      end
      if (n == 11) idle();
      tick();
      n++;
    end
    check("reclear_cycles", 32'(n), 32'd32);
    bus.raddr = {5'd20, 5'd5};
    #1;
    check("reg5_ignored", bus.rdata[31:0], 32'h0);
    check("sb5_ignored", 32'(bus.rd_pending[0]), 32'd0);
    check("reg20_wiped", bus.rdata[63:32], 32'h0);
    bus.raddr = {5'd12, 5'd3};
    #1;
    check("sb12_dropped", 32'(bus.rd_pending[1]), 32'd0);
    check("reg3_wiped", bus.rdata[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
